load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width of the data RAM (256 bytes).
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  input  1 and req_ready  output  1, request handshake from the execute stage.
REQ-005 SHALL have req_we  input  1 (1=store), req_func3  input  3 (F3_BYTE/HALF/WORD/UBYTE/UHALF), req_addr  input  32, req_wdata  input  32.
REQ-006 SHALL have mem_en  output  1, mem_we  output  4 (byte enables), mem_addr  output  ADDR_W-2 (word address), mem_wdata  output  32, mem_rdata  input  32; the RAM is synchronous with 1-cycle read latency.
REQ-007 SHALL have rsp_valid  output  1, rsp_ready  input  1, rsp_rdata  output  32, rsp_err  output  1, response to writeback.

Function
REQ-008 SHALL implement FSM IDLE, ACCESS, LOAD_DATA, RESP; req_ready = 1 only in IDLE.
REQ-009 SHALL capture request fields on the req_valid && req_ready edge and go IDLE -> ACCESS.
REQ-010 In ACCESS SHALL drive mem_en=1 and mem_addr=addr[ADDR_W-1:2] for one cycle; mem_en=0 and mem_we=0 in every other state.
REQ-011 Store lanes: byte mem_we=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}; half mem_we=4'b0011<<{addr[1],1'b0}, mem_wdata={2{wdata[15:0]}}; word mem_we=4'b1111, mem_wdata=wdata.
REQ-012 Store: ACCESS -> RESP; load: ACCESS -> LOAD_DATA -> RESP.
REQ-013 In LOAD_DATA SHALL register mem_rdata, select the lane by addr[1:0], and sign-extend (BYTE/HALF) or zero-extend (UBYTE/UHALF) into rsp_rdata.
REQ-014 Latency from accept edge to rsp_valid SHALL be 2 cycles for a store and 3 cycles for a load, with no backpressure.
REQ-015 In RESP SHALL hold rsp_valid=1 and keep rsp_rdata/rsp_err stable until rsp_ready=1, then go RESP -> IDLE; rsp_rdata=0 for stores.
REQ-016 Illegal func3 (load 3/6/7; store other than 0/1/2) SHALL go ACCESS -> RESP with rsp_err=1, mem_en=0.
REQ-017 Address bits above ADDR_W-1 SHALL be ignored (wrap-around within RAM).
REQ-018 No new request SHALL be accepted while a response is pending; only one transaction in flight.

Reset
REQ-019 While rst_n=0 SHALL force state=IDLE, req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-020 Reset in any state SHALL abort the transaction with no write committed after reset assertion and no response issued.

Configuration
REQ-021 Macro LSU_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go ACCESS -> RESP with rsp_err=1, mem_en=0.
REQ-022 Macro undefined: offending low address bits SHALL be cleared (natural alignment) and the access SHALL proceed with rsp_err=0.

Structure
REQ-023 Package lsu_pkg SHALL hold the FSM state enum typedef and the byte-enable/lane constants; func3 codes SHALL come from the existing define.svh macros.
REQ-024 Combinational sub-module lsu_load_align SHALL perform lane selection and extension (mem word, addr[1:0], func3 -> 32-bit result).

Verification
REQ-025 SW 0xDEADBEEF @0x10 -> cycle+1 mem_en=1, mem_we=4'b1111, mem_addr=0x04; cycle+2 rsp_valid=1, rsp_err=0.
REQ-026 LB @0x13, mem_rdata=0xDEADBEEF -> cycle+3 rsp_rdata=0xFFFFFFDE; LHU @0x12 -> 0x0000DEAD; LBU @0x10 -> 0x000000EF.
REQ-027 SH 0xABCD1234 @0x12 -> mem_we=4'b1100, mem_wdata=0x12341234.
REQ-028 LW @0x11: with macro -> rsp_err=1 at cycle+2, mem_en never asserted; without macro -> mem_addr=0x04, rsp_err=0 at cycle+3.
REQ-029 Load with rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata held, req_ready=0; rst_n pulsed low in ACCESS of an SW -> mem_we=0 immediately, rsp_valid never asserts, req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit.
//   - F3_* funct3 codes: taken from the project-wide define.svh. They are
//     provided here, each behind its own guard, so this slice also builds
//     on its own.
//   - lsu_state_e: load/store FSM state encoding.
//   - BE_*: byte-enable lane patterns before shifting to the target lane.
//   - store_be / store_data: store lane steering helpers.
// -----------------------------------------------------------------------------
`ifndef F3_BYTE
`define F3_BYTE  3'd0
`endif
`ifndef F3_HALF
`define F3_HALF  3'd1
`endif
`ifndef F3_WORD
`define F3_WORD  3'd2
`endif
`ifndef F3_UBYTE
`define F3_UBYTE 3'd4
`endif
`ifndef F3_UHALF
`define F3_UHALF 3'd5
`endif

package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_LOAD_DATA = 2'd2,
    ST_RESP      = 2'd3
  } lsu_state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Byte enables for a store of the given size at byte offset off.
  function automatic logic [3:0] store_be(input logic [2:0] func3, input logic [1:0] off);
    logic [3:0] be;
    be = BE_NONE;
    case (func3)
      `F3_BYTE: be = BE_BYTE << off;
      `F3_HALF: be = BE_HALF << {off[1], 1'b0};
      `F3_WORD: be = BE_WORD;
      default:  be = BE_NONE;
    endcase
    return be;
  endfunction

  // Replicate the store data across every lane so the byte enables alone
  // select what lands in the RAM.
  function automatic logic [31:0] store_data(input logic [2:0] func3, input logic [31:0] wdata);
    logic [31:0] d;
    d = 32'h0000_0000;
    case (func3)
      `F3_BYTE: d = {4{wdata[7:0]}};
      `F3_HALF: d = {2{wdata[15:0]}};
      `F3_WORD: d = wdata;
      default:  d = 32'h0000_0000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational lane selection and sign/zero extension for loads.
// Ports:
//   i_word  [31:0] raw RAM word
//   i_off   [1:0]  byte offset within the word (already aligned for halves)
//   i_func3 [2:0]  load size/sign code (F3_BYTE/HALF/WORD/UBYTE/UHALF)
//   o_data  [31:0] extended load result (0 for unknown codes)
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword out of the word.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    if (i_off[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    o_data = 32'h0000_0000;
    case (i_func3)
      `F3_BYTE:  o_data = {{24{w_byte[7]}}, w_byte};
      `F3_HALF:  o_data = {{16{w_half[15]}}, w_half};
      `F3_WORD:  o_data = i_word;
      `F3_UBYTE: o_data = {24'h00_0000, w_byte};
      `F3_UHALF: o_data = {16'h0000, w_half};
      default:   o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store unit between the execute stage and a
// synchronous data RAM (1-cycle read latency).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only when idle)
//   req_we, req_func3               1 = store; access size/sign code
//   req_addr, req_wdata             byte address (upper bits wrap), store data
//   mem_en, mem_we[3:0]             RAM enable and byte enables
//   mem_addr[ADDR_W-3:0]            RAM word address
//   mem_wdata, mem_rdata            RAM write / read data
//   rsp_valid/rsp_ready             response handshake to writeback
//   rsp_rdata, rsp_err              load result (0 for stores), error flag
// Configuration macro:
//   LSU_MISALIGN_CHECK_EN  defined: misaligned half/word accesses are
//                          rejected with rsp_err. Undefined: the offending
//                          low address bits are cleared and the access runs.
// Timing: accept edge -> ACCESS (RAM enabled) -> RESP for stores/errors,
// or -> LOAD_DATA -> RESP for loads; so rsp_valid follows 2 or 3 cycles
// after the accept edge.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  lsu_state_e        r_state, w_state_nxt;
  logic              r_we, w_we_nxt;
  logic              r_err, w_err_nxt;
  logic [2:0]        r_func3, w_func3_nxt;
  logic [1:0]        r_off, w_off_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic              r_mem_en, w_mem_en_nxt;
  logic [3:0]        r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-3:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]       r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;

  logic              w_is_half, w_is_word, w_legal, w_req_err;
  logic [ADDR_W-1:0] w_addr_in, w_req_addr;
  logic [31:0]       w_load_data;
  logic              w_unused_addr;

  // Address bits above the RAM size are deliberately dropped (wrap-around).
  assign w_unused_addr = ^req_addr[31:ADDR_W];

  // Classify the incoming request: legality, size, and effective address.
  always_comb begin
    w_addr_in  = req_addr[ADDR_W-1:0];
    w_is_half  = (req_func3 == `F3_HALF) || (req_func3 == `F3_UHALF);
    w_is_word  = (req_func3 == `F3_WORD);
    w_legal    = 1'b0;
    w_req_err  = 1'b0;
    w_req_addr = w_addr_in;
    case (req_func3)
      `F3_BYTE, `F3_HALF, `F3_WORD: w_legal = 1'b1;
      `F3_UBYTE, `F3_UHALF:         w_legal = !req_we;
      default:                      w_legal = 1'b0;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    w_req_err = !w_legal
              || (w_is_half && w_addr_in[0])
              || (w_is_word && (w_addr_in[1:0] != 2'b00));
`else
    w_req_err = !w_legal;
    if (w_is_word) begin
      w_req_addr[1:0] = 2'b00;
    end else if (w_is_half) begin
      w_req_addr[0] = 1'b0;
    end else begin
      w_req_addr = w_addr_in;
    end
`endif
  end

  lsu_load_align u_load_align (
    .i_word  (mem_rdata),
    .i_off   (r_off),
    .i_func3 (r_func3),
    .o_data  (w_load_data)
  );

  // Next-state and next-output logic; RAM strobes default low every cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_we_nxt        = r_we;
    w_err_nxt       = r_err;
    w_func3_nxt     = r_func3;
    w_off_nxt       = r_off;
    w_req_ready_nxt = r_req_ready;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = BE_NONE;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state_nxt     = ST_ACCESS;
          w_req_ready_nxt = 1'b0;
          w_we_nxt        = req_we;
          w_err_nxt       = w_req_err;
          w_func3_nxt     = req_func3;
          w_off_nxt       = w_req_addr[1:0];
          // Rejected requests never touch the RAM.
          w_mem_en_nxt    = !w_req_err;
          w_mem_we_nxt    = (req_we && !w_req_err) ? store_be(req_func3, w_req_addr[1:0]) : BE_NONE;
          w_mem_addr_nxt  = w_req_addr[ADDR_W-1:2];
          w_mem_wdata_nxt = req_we ? store_data(req_func3, req_wdata) : r_mem_wdata;
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (r_err || r_we) begin
          w_state_nxt     = ST_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = r_err;
          w_rsp_rdata_nxt = 32'h0000_0000;
        end else begin
          w_state_nxt = ST_LOAD_DATA;
        end
      end
      ST_LOAD_DATA: begin
        // RAM read data is valid this cycle; capture the extended lane.
        w_state_nxt     = ST_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = w_load_data;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and registered-output update; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_func3     <= 3'd0;
      r_off       <= 2'd0;
      r_req_ready <= 1'b1;
      r_mem_en    <= 1'b0;
      r_mem_we    <= BE_NONE;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0000_0000;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_we        <= w_we_nxt;
      r_err       <= w_err_nxt;
      r_func3     <= w_func3_nxt;
      r_off       <= w_off_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a 64-word RAM model. A table of
// single transactions is applied in a loop; back-pressure and mid-access
// reset are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous, read-before-write, preloaded on its first edge.
  logic [31:0] ram [0:63];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) ram[i] <= {4{i[7:0]}};
      ram[4] <= 32'hDEAD_BEEF;
      ram[5] <= 32'h8001_7F02;
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic [3:0]  be;
    logic [5:0]  maddr;
    logic [31:0] mwdata;
    logic [3:0]  lat;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input logic [5:0] ma, input logic [31:0] mwd);
    vec_t v;
    v = '{we: 1'b1, f3: f3, addr: addr, wdata: wd, en: 1'b1, be: be, maddr: ma,
          mwdata: mwd, lat: 4'd2, err: 1'b0, rd: 32'h0};
    return v;
  endfunction

  function automatic vec_t ld(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [5:0] ma, input logic [31:0] rd);
    vec_t v;
    v = '{we: 1'b0, f3: f3, addr: addr, wdata: 32'h0, en: 1'b1, be: 4'h0, maddr: ma,
          mwdata: 32'h0, lat: 4'd3, err: 1'b0, rd: rd};
    return v;
  endfunction

  function automatic vec_t bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    vec_t v;
    v = '{we: we, f3: f3, addr: addr, wdata: 32'hFFFF_FFFF, en: 1'b0, be: 4'h0, maddr: 6'h0,
          mwdata: 32'h0, lat: 4'd2, err: 1'b1, rd: 32'h0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat = 0;
    int          en_cnt = 0;
    int          en_cyc = 0;
    int          stray = 0;
    logic [3:0]  g_be = 4'h0;
    logic [5:0]  g_ma = 6'h0;
    logic [31:0] g_wd = 32'h0;
    logic        g_err = 1'b0;
    logic [31:0] g_rd = 32'h0;
    @(negedge clk);
    chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_func3 = v.f3;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_en) begin
        en_cnt++; en_cyc = c; g_be = mem_we; g_ma = mem_addr; g_wd = mem_wdata;
      end else if (mem_we != 4'h0) begin
        stray++;
      end
      if (rsp_valid) begin
        lat = c; g_err = rsp_err; g_rd = rsp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d rsp_err", idx), 32'(g_err), 32'(v.err));
    chk($sformatf("v%0d mem_en cycles", idx), 32'(en_cnt), 32'(v.en));
    chk($sformatf("v%0d mem_we without mem_en", idx), 32'(stray), 32'd0);
    if (v.en) begin
      chk($sformatf("v%0d mem_en cycle", idx), 32'(en_cyc), 32'd1);
      chk($sformatf("v%0d mem_we", idx), 32'(g_be), 32'(v.be));
      chk($sformatf("v%0d mem_addr", idx), 32'(g_ma), 32'(v.maddr));
    end
    if (v.en && v.we) chk($sformatf("v%0d mem_wdata", idx), g_wd, v.mwdata);
    if (!v.err) chk($sformatf("v%0d rsp_rdata", idx), g_rd, v.rd);
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];

  initial begin
    int seen;
    // Table of single transactions, applied in order (RAM state carries over).
    vecs.push_back(st(3'd2, 32'h10, 32'hDEAD_BEEF, 4'b1111, 6'h04, 32'hDEAD_BEEF));
    vecs.push_back(ld(3'd0, 32'h13, 6'h04, 32'hFFFF_FFDE));
    vecs.push_back(ld(3'd5, 32'h12, 6'h04, 32'h0000_DEAD));
    vecs.push_back(ld(3'd4, 32'h10, 6'h04, 32'h0000_00EF));
    vecs.push_back(ld(3'd1, 32'h10, 6'h04, 32'hFFFF_BEEF));
    vecs.push_back(ld(3'd0, 32'h11, 6'h04, 32'hFFFF_FFBE));
    vecs.push_back(ld(3'd2, 32'h10, 6'h04, 32'hDEAD_BEEF));
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back(bad(1'b0, 3'd2, 32'h11));
`else
    vecs.push_back(ld(3'd2, 32'h11, 6'h04, 32'hDEAD_BEEF));
`endif
    vecs.push_back(ld(3'd1, 32'h1000_0016, 6'h05, 32'hFFFF_8001));
    vecs.push_back(ld(3'd4, 32'hFFFF_FF15, 6'h05, 32'h0000_007F));
    vecs.push_back(st(3'd1, 32'h12, 32'hABCD_1234, 4'b1100, 6'h04, 32'h1234_1234));
    vecs.push_back(st(3'd0, 32'h21, 32'h0000_00A5, 4'b0010, 6'h08, 32'hA5A5_A5A5));
    vecs.push_back(ld(3'd0, 32'h21, 6'h08, 32'hFFFF_FFA5));
    vecs.push_back(bad(1'b0, 3'd3, 32'h10));
    vecs.push_back(bad(1'b0, 3'd6, 32'h10));
    vecs.push_back(bad(1'b0, 3'd7, 32'h10));
    vecs.push_back(bad(1'b1, 3'd4, 32'h10));
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back(bad(1'b1, 3'd1, 32'h13));
    vecs.push_back(ld(3'd2, 32'h10, 6'h04, 32'h1234_BEEF));
`else
    vecs.push_back(st(3'd1, 32'h13, 32'h0000_5678, 4'b1100, 6'h04, 32'h5678_5678));
    vecs.push_back(ld(3'd2, 32'h10, 6'h04, 32'h5678_BEEF));
`endif
    vecs.push_back(st(3'd2, 32'h3FC, 32'h0102_0304, 4'b1111, 6'h3F, 32'h0102_0304));
    vecs.push_back(ld(3'd2, 32'hFC, 6'h3F, 32'h0102_0304));

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-pressure: LW @0x14 held in RESP for 3 cycles while a store knocks.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h14; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      if (rsp_valid) begin seen = c; break; end
      @(posedge clk); #1;
    end
    chk("bp latency", 32'(seen), 32'd3);
    chk("bp first rdata", rsp_rdata, 32'h8001_7F02);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'd2; req_addr = 32'h18; req_wdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp hold%0d rsp_rdata", k), rsp_rdata, 32'h8001_7F02);
      chk($sformatf("bp hold%0d rsp_err", k), 32'(rsp_err), 32'd0);
      chk($sformatf("bp hold%0d req_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp hold%0d mem_en", k), 32'(mem_en), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp release req_ready", 32'(req_ready), 32'd1);

    // Reset asserted during the ACCESS cycle of a store to word 6.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'd2; req_addr = 32'h18; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst access mem_en", 32'(mem_en), 32'd1);
    chk("rst access mem_we", 32'(mem_we), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("rst no response", 32'(seen), 32'd0);
    chk("rst ram word6 untouched", ram[6], 32'h0606_0606);
    chk("rst req_ready after", 32'(req_ready), 32'd1);
    run_vec(ld(3'd2, 32'h18, 6'h06, 32'h0606_0606), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
